sobol_rng_multidim: RTL and testbench

Parametrised multi-dimension Sobol low-discrepancy RNG for the stochastic-computing datapath. It generalises the single-dimension generator:
- NUM_DIM independent dimensions share one step counter and one least-significant-zero encoder.
- Direction vectors are run-time loadable.
- Adds restart, wrap indication and an output-valid handshake.
- A per-dimension shift chain feeds NUM_RNG parallel consumers, each one step later than the previous.

---
 rtl/sobol_pkg.sv | 18 +
 rtl/sobol_lsz.sv | 19 +
 rtl/sobol_rng_multidim.sv | 158 +++++++++++++++
 tb/tb_sobol_rng_multidim.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sobol_pkg.sv
// Shared types and defaults for the multi-dimension Sobol generator.
package sobol_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_NUM_DIM = 2;
  localparam int DEFAULT_NUM_RNG = 8;

  typedef logic [DEFAULT_WIDTH-1:0] dirvec_t;
  typedef dirvec_t [DEFAULT_WIDTH-1:0] dirvec_set_t;

  typedef enum logic [1:0] {IDLE, FILL, RUN} rng_state_e;

  // Van der Corput direction vector k for a given width: a single bit walking down from the MSB.
  function automatic logic [31:0] default_dirvec(input int width, input int k);
    return 32'd1 << (width - 1 - k);
  endfunction

endpackage

// File: rtl/sobol_lsz.sv
// Least-significant-zero priority encoder shared by all Sobol dimensions.
// For an all-ones input the index is don't-care; the caller handles that case.
module sobol_lsz #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [IDX_W-1:0] idx
);

  // Scan from the MSB down so the lowest zero bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!value[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sobol_rng_multidim.sv
// Multi-dimension Sobol low-discrepancy generator with run-time loadable
// direction vectors, restart, wrap pulse and a per-dimension shift chain.
// Optional random digital shift (scramble mask) enabled by SOBOL_SCRAMBLE_EN.
module sobol_rng_multidim
  import sobol_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_DIM = DEFAULT_NUM_DIM,
  parameter int NUM_RNG = DEFAULT_NUM_RNG,
  parameter int DIM_W   = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1,
  parameter int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             restart,
  input  logic                             dv_wr_en,
  input  logic [DIM_W-1:0]                 dv_wr_dim,
  input  logic [IDX_W-1:0]                 dv_wr_idx,
  input  logic [WIDTH-1:0]                 dv_wr_data,
`ifdef SOBOL_SCRAMBLE_EN
  input  logic                             scr_wr_en,
  input  logic [DIM_W-1:0]                 scr_wr_dim,
  input  logic [WIDTH-1:0]                 scr_wr_data,
`endif
  output logic [NUM_RNG*NUM_DIM*WIDTH-1:0] rng_seq,
  output logic                             rng_valid,
  output logic                             seq_wrap
);

  localparam int FILL_W = $clog2(NUM_RNG + 1);

  logic [WIDTH-1:0] cnt;
  logic [IDX_W-1:0] lsz;
  logic             cnt_full;
  logic [WIDTH-1:0] dir_vec    [NUM_DIM][WIDTH];
  logic [WIDTH-1:0] state      [NUM_DIM];
  logic [WIDTH-1:0] next_state [NUM_DIM];
  logic [WIDTH-1:0] tap_in     [NUM_DIM];
  logic [WIDTH-1:0] taps       [NUM_RNG][NUM_DIM];
  rng_state_e       fsm, fsm_next;
  logic [FILL_W-1:0] fill_cnt, fill_next;

  sobol_lsz #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lsz (
    .value(cnt),
    .idx  (lsz)
  );

  assign cnt_full  = &cnt;
  assign rng_valid = (fsm == RUN);

`ifdef SOBOL_SCRAMBLE_EN
  logic [WIDTH-1:0] mask [NUM_DIM];

  // Scramble mask registers; only rst_n clears them, restart leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIM; d++) mask[d] <= '0;
    end else if (scr_wr_en && (int'(scr_wr_dim) < NUM_DIM)) begin
      mask[scr_wr_dim] <= scr_wr_data;
    end
  end
`endif

  // Next Sobol point per dimension; the last point of the period returns to zero.
  always_comb begin
    for (int d = 0; d < NUM_DIM; d++) begin
      next_state[d] = cnt_full ? '0 : (state[d] ^ dir_vec[d][lsz]);
`ifdef SOBOL_SCRAMBLE_EN
      tap_in[d] = next_state[d] ^ mask[d];
`else
      tap_in[d] = next_state[d];
`endif
    end
  end

  // Direction-vector storage; a write lands at the edge so a concurrent step still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIM; d++)
        for (int k = 0; k < WIDTH; k++)
          dir_vec[d][k] <= WIDTH'(default_dirvec(WIDTH, k));
    end else if (dv_wr_en && (int'(dv_wr_dim) < NUM_DIM) && (int'(dv_wr_idx) < WIDTH)) begin
      dir_vec[dv_wr_dim][dv_wr_idx] <= dv_wr_data;
    end
  end

  // Step counter, Sobol state, shift chain and wrap pulse; restart wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      seq_wrap <= 1'b0;
      for (int d = 0; d < NUM_DIM; d++) state[d] <= '0;
      for (int r = 0; r < NUM_RNG; r++)
        for (int d = 0; d < NUM_DIM; d++) taps[r][d] <= '0;
    end else if (restart) begin
      cnt      <= '0;
      seq_wrap <= 1'b0;
      for (int d = 0; d < NUM_DIM; d++) state[d] <= '0;
      for (int r = 0; r < NUM_RNG; r++)
        for (int d = 0; d < NUM_DIM; d++) taps[r][d] <= '0;
    end else begin
      seq_wrap <= 1'b0;
      if (enable) begin
        cnt      <= cnt + WIDTH'(1);
        seq_wrap <= cnt_full;
        for (int d = 0; d < NUM_DIM; d++) begin
          state[d]   <= next_state[d];
          taps[0][d] <= tap_in[d];
        end
        for (int r = 1; r < NUM_RNG; r++)
          for (int d = 0; d < NUM_DIM; d++) taps[r][d] <= taps[r-1][d];
      end
    end
  end

  // FSM state and fill counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      fill_cnt <= '0;
    end else begin
      fsm      <= fsm_next;
      fill_cnt <= fill_next;
    end
  end

  // Track how many steps have entered the chain; valid once every tap has been written.
  always_comb begin
    fsm_next  = fsm;
    fill_next = fill_cnt;
    if (restart) begin
      fsm_next  = IDLE;
      fill_next = '0;
    end else if (enable) begin
      case (fsm)
        IDLE: begin
          fill_next = FILL_W'(1);
          fsm_next  = (NUM_RNG <= 1) ? RUN : FILL;
        end
        FILL: begin
          fill_next = fill_cnt + FILL_W'(1);
          if (int'(fill_next) >= NUM_RNG) fsm_next = RUN;
        end
        default: fsm_next = RUN;
      endcase
    end
  end

  // Flatten the shift chain onto the output bus: tap r, dimension d.
  always_comb begin
    rng_seq = '0;
    for (int r = 0; r < NUM_RNG; r++)
      for (int d = 0; d < NUM_DIM; d++)
        rng_seq[(r*NUM_DIM + d)*WIDTH +: WIDTH] = taps[r][d];
  end

endmodule

// File: tb/tb_sobol_rng_multidim.sv
// Scoreboard bench for sobol_rng_multidim at WIDTH=4, NUM_DIM=2, NUM_RNG=8.
// Exercises SOBOL_SCRAMBLE_EN as well when that macro is defined.
module tb_sobol_rng_multidim;

  localparam int W  = 4;
  localparam int ND = 2;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic restart = 1'b0;
  logic dv_wr_en = 1'b0;
  logic [0:0] dv_wr_dim = '0;
  logic [1:0] dv_wr_idx = '0;
  logic [3:0] dv_wr_data = '0;
  logic [NR*ND*W-1:0] rng_seq;
  logic rng_valid;
  logic seq_wrap;
`ifdef SOBOL_SCRAMBLE_EN
  logic scr_wr_en = 1'b0;
  logic [0:0] scr_wr_dim = '0;
  logic [3:0] scr_wr_data = '0;
`endif

  sobol_rng_multidim #(.WIDTH(W), .NUM_DIM(ND), .NUM_RNG(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .restart    (restart),
    .dv_wr_en   (dv_wr_en),
    .dv_wr_dim  (dv_wr_dim),
    .dv_wr_idx  (dv_wr_idx),
    .dv_wr_data (dv_wr_data),
`ifdef SOBOL_SCRAMBLE_EN
    .scr_wr_en  (scr_wr_en),
    .scr_wr_dim (scr_wr_dim),
    .scr_wr_data(scr_wr_data),
`endif
    .rng_seq    (rng_seq),
    .rng_valid  (rng_valid),
    .seq_wrap   (seq_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] tap7;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] hist[$];
  int checks = 0;
  int errors = 0;

  // Default van der Corput sequence for dimension 0 over one full period.
  logic [3:0] seq0 [16] = '{4'd8, 4'd12, 4'd4, 4'd6, 4'd14, 4'd10, 4'd2, 4'd3,
                            4'd11, 4'd15, 4'd7, 4'd5, 4'd13, 4'd9, 4'd1, 4'd0};
  logic [3:0] dim1_vec [4] = '{4'd8, 4'd12, 4'd10, 4'd15};

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rs, input logic wr,
                               input logic [0:0] dim, input logic [1:0] idx, input logic [3:0] data);
    @(negedge clk);
    enable     = en;
    restart    = rs;
    dv_wr_en   = wr;
    dv_wr_dim  = dim;
    dv_wr_idx  = idx;
    dv_wr_data = data;
  endtask

  // Record the expected result of a step about to be issued; tap7 comes from the bench's own history.
  task automatic pushStep(input logic [3:0] d0, input logic [3:0] d1, input logic valid, input logic wrap);
    exp_t e;
    hist.push_back(d0);
    e.d0    = d0;
    e.d1    = d1;
    e.tap7  = (hist.size() >= 8) ? hist[hist.size() - 8] : 4'd0;
    e.valid = valid;
    e.wrap  = wrap;
    expq.push_back(e);
  endtask

  // Monitor: every edge that took a step is checked at the following falling edge.
  initial begin
    logic stepped;
    exp_t e;
    forever begin
      @(posedge clk);
      stepped = rst_n && enable && !restart;
      @(negedge clk);
      if (stepped) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_step: got a step, required none");
        end else begin
          e = expq.pop_front();
          checkOutput("tap0_dim0", rng_seq[3:0], e.d0);
          checkOutput("tap0_dim1", rng_seq[7:4], e.d1);
          checkOutput("tap7_dim0", rng_seq[59:56], e.tap7);
          checkOutput("rng_valid", {3'b0, rng_valid}, {3'b0, e.valid});
          checkOutput("seq_wrap", {3'b0, seq_wrap}, {3'b0, e.wrap});
        end
      end
    end
  end

  initial begin
    // Reset state.
    #12;
    checkOutput("reset_taps", {3'b0, |rng_seq}, 4'd0);
    checkOutput("reset_valid", {3'b0, rng_valid}, 4'd0);
    checkOutput("reset_wrap", {3'b0, seq_wrap}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SOBOL_SCRAMBLE_EN
    // Mask dim0 with all ones, then three steps; dim1 stays unscrambled.
    @(negedge clk);
    scr_wr_en = 1'b1; scr_wr_dim = 1'b0; scr_wr_data = 4'hF;
    @(negedge clk);
    scr_wr_en = 1'b0;
    pushStep(4'd7, 4'd8, 1'b0, 1'b0);  applyStimulus(1, 0, 0, 0, 0, 0);
    pushStep(4'd3, 4'd12, 1'b0, 1'b0); applyStimulus(1, 0, 0, 0, 0, 0);
    pushStep(4'd11, 4'd4, 1'b0, 1'b0); applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("scr_reset_taps", {3'b0, |rng_seq}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    pushStep(4'd8, 4'd8, 1'b0, 1'b0);  applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
`endif

    // Full period plus one with continuous enable: fill, wrap pulse, valid held across the wrap.
    for (int k = 0; k < 17; k++) begin
      pushStep(seq0[k % 16], seq0[k % 16], (k + 1) >= NR, k == 15);
      applyStimulus(1, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("valid_hold", {3'b0, rng_valid}, 4'd1);
    checkOutput("wrap_single", {3'b0, seq_wrap}, 4'd0);

    // Plain restart, then load dim1 with {8,12,10,15}.
    applyStimulus(0, 1, 0, 0, 0, 0);
    hist.delete();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 1, 1'b1, 2'(k), dim1_vec[k]);
      if (k == 0) checkOutput("restart_valid", {3'b0, rng_valid}, 4'd0);
    end
    // dim1: 0^8=8, 8^12=4, 4^8=12, 12^10=6; dim0 follows the default sequence.
    pushStep(4'd8, 4'd8, 1'b0, 1'b0);   applyStimulus(1, 0, 0, 0, 0, 0);
    pushStep(4'd12, 4'd4, 1'b0, 1'b0);  applyStimulus(1, 0, 0, 0, 0, 0);
    pushStep(4'd4, 4'd12, 1'b0, 1'b0);  applyStimulus(1, 0, 0, 0, 0, 0);
    pushStep(4'd6, 4'd6, 1'b0, 1'b0);   applyStimulus(1, 0, 0, 0, 0, 0);

    // Restart together with enable: the enable is ignored and everything clears.
    applyStimulus(1, 1, 0, 0, 0, 0);
    hist.delete();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("restart_en_taps", {3'b0, |rng_seq}, 4'd0);
    checkOutput("restart_en_valid", {3'b0, rng_valid}, 4'd0);
    checkOutput("restart_en_wrap", {3'b0, seq_wrap}, 4'd0);
    // Loaded dim1 vector 12 is retained: second step gives 8^12=4.
    pushStep(4'd8, 4'd8, 1'b0, 1'b0);   applyStimulus(1, 0, 0, 0, 0, 0);
    pushStep(4'd12, 4'd4, 1'b0, 1'b0);  applyStimulus(1, 0, 0, 0, 0, 0);

    // cnt=2 selects vector 0; rewrite dim1 vector 0 to 1 in the same cycle as the step.
    pushStep(4'd4, 4'd12, 1'b0, 1'b0);  applyStimulus(1, 0, 1, 1'b1, 2'd0, 4'd1);
    pushStep(4'd6, 4'd6, 1'b0, 1'b0);   applyStimulus(1, 0, 0, 0, 0, 0);
    pushStep(4'd14, 4'd7, 1'b0, 1'b0);  applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, required 0", expq.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
